// File: rtl/hamming_pkg.sv
// Shared constants and types for the serial (15,11) Hamming link.
package hamming_pkg;
    localparam int HAM_DATA_W = 11;
    localparam int HAM_CODE_W = 15;
    localparam int HAM_LAT    = 30;
    localparam int HAM_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } tx_state_e;
endpackage

// File: rtl/hamming_link_ctrl_if.sv
// Word-side handshakes and serial chain signals of the link controller.
interface hamming_link_ctrl_if import hamming_pkg::*; #(
    parameter int DATA_W = HAM_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              sl_inn;
    logic              shift;
    logic              sl_out;

    modport master (
        output in_data, in_valid, out_ready, sl_out,
        input  in_ready, out_data, out_valid, sl_inn, shift
    );

    modport slave (
        input  in_data, in_valid, out_ready, sl_out,
        output in_ready, out_data, out_valid, sl_inn, shift
    );
endinterface

// File: rtl/hamming_deser.sv
// RX capture: samples decoded bits LSB first and holds the word until taken.
module hamming_deser import hamming_pkg::*; #(
    parameter int DATA_W = HAM_DATA_W,
    parameter int CNT_W  = HAM_CNT_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              i_shift,
    input  logic              i_start,
    input  logic              i_bit,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_active,
    output logic              stall_req,
    output logic [CNT_W-1:0]  o_rx_frames
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    logic              r_act, w_act;
    logic [BW-1:0]     r_cnt, w_cnt;
    logic [DATA_W-1:0] r_sh, w_sh;
    logic [DATA_W-1:0] r_data, w_data;
    logic              r_valid, w_valid;
    logic [CNT_W-1:0]  r_rx, w_rx;
    logic [DATA_W-1:0] w_smp;

    always_comb begin
        w_act   = r_act;
        w_cnt   = r_cnt;
        w_sh    = r_sh;
        w_data  = r_data;
        w_valid = r_valid;
        w_rx    = r_rx;
        w_smp   = {i_bit, r_sh[DATA_W-1:1]};
        if (r_valid && i_ready)
            w_valid = 1'b0;
        if (i_shift && r_act) begin
            w_sh = w_smp;
            if (r_cnt == LAST) begin
                w_act   = 1'b0;
                w_cnt   = '0;
                w_data  = w_smp;
                w_valid = 1'b1;
                w_rx    = r_rx + 1'b1;
            end else begin
                w_cnt = r_cnt + 1'b1;
            end
        end else if (i_shift && i_start) begin
            w_sh  = w_smp;
            w_act = 1'b1;
            w_cnt = BW'(1);
        end
    end

    // Predicts a last-bit sample that would collide with an unconsumed word.
    assign stall_req = w_act && w_valid && (w_cnt == LAST);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_act   <= 1'b0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_rx    <= '0;
        end else begin
            r_act   <= w_act;
            r_cnt   <= w_cnt;
            r_sh    <= w_sh;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_rx    <= w_rx;
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_active    = r_act;
    assign o_rx_frames = r_rx;
endmodule

// File: rtl/hamming_link_ctrl.sv
// Frame-slot sequencer feeding the serial Hamming chain and collecting its output.
module hamming_link_ctrl import hamming_pkg::*; #(
    parameter int DATA_W    = HAM_DATA_W,
    parameter int FRAME_LEN = HAM_CODE_W,
    parameter int LAT       = HAM_LAT,
    parameter int CNT_W     = HAM_CNT_W
) (
    input  logic               clk,
    input  logic               RST,
    hamming_link_ctrl_if.slave bus,
    output logic               busy,
    output logic [CNT_W-1:0]   tx_frames,
    output logic [CNT_W-1:0]   rx_frames
);
    localparam int PW = $clog2(FRAME_LEN);
    localparam int FW = $clog2(LAT / FRAME_LEN + 2);
    localparam logic [PW-1:0] P_LAST = PW'(FRAME_LEN - 1);

    tx_state_e         r_state, w_state;
    logic [PW-1:0]     r_pos, w_pos;
    logic [DATA_W-1:0] r_txsh, w_txsh;
    logic              r_sl, w_sl;
    logic              r_shift, w_shift;
    logic              r_dslot, w_dslot;
    logic              r_stg_v, w_stg_v;
    logic [DATA_W-1:0] r_stg, w_stg;
    logic              r_rdy, w_rdy;
    logic [LAT-1:0]    r_tag, w_tag;
    logic [FW-1:0]     r_infl, w_infl;
    logic [CNT_W-1:0]  r_tx, w_tx;

    logic              w_acc, w_bnd, w_ins, w_tout;
    logic              w_have, w_load, w_cap, w_stall;
    logic [DATA_W-1:0] w_word;

    always_comb begin
        w_state = r_state;
        w_pos   = r_pos;
        w_txsh  = r_txsh;
        w_sl    = r_sl;
        w_dslot = r_dslot;
        w_stg_v = r_stg_v;
        w_stg   = r_stg;
        w_tag   = r_tag;
        w_tx    = r_tx;
        w_acc   = bus.in_valid && r_rdy;
        w_bnd   = r_shift && (r_pos == P_LAST);
        w_ins   = r_shift && r_dslot && (r_pos == '0);
        w_tout  = r_shift && r_tag[LAT-1];
        w_have  = r_stg_v || w_acc;
        w_word  = r_stg_v ? r_stg : bus.in_data;
        w_infl  = r_infl + FW'(w_ins) - FW'(w_tout);
        if (w_acc) begin
            w_stg_v = 1'b1;
            w_stg   = bus.in_data;
            w_tx    = r_tx + 1'b1;
        end
        if (r_shift) begin
            w_tag  = {r_tag[LAT-2:0], w_ins};
            w_pos  = r_pos + 1'b1;
            w_sl   = r_txsh[0];
            w_txsh = r_txsh >> 1;
        end
        if (w_bnd) begin
            w_pos   = '0;
            w_sl    = 1'b0;
            w_txsh  = '0;
            w_dslot = 1'b0;
        end
        // A word accepted this very cycle may go straight into the shifter.
        w_load = w_have && (w_bnd || (r_state == ST_IDLE));
        if (w_load) begin
            w_stg_v = 1'b0;
            w_pos   = '0;
            w_sl    = w_word[0];
            w_txsh  = w_word >> 1;
            w_dslot = 1'b1;
        end
        unique case (r_state)
            ST_IDLE:
                if (w_acc)
                    w_state = ST_RUN;
            ST_RUN:
                if (w_bnd && !w_have)
                    w_state = ST_DRAIN;
            ST_DRAIN:
                if (w_acc)
                    w_state = ST_RUN;
                else if (w_bnd && (w_infl == '0) && !w_tout && !w_cap)
                    w_state = ST_IDLE;
            default:
                w_state = ST_IDLE;
        endcase
        w_rdy   = !w_stg_v;
        w_shift = (w_state != ST_IDLE) && !w_stall;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
            r_txsh  <= '0;
            r_sl    <= 1'b0;
            r_shift <= 1'b0;
            r_dslot <= 1'b0;
            r_stg_v <= 1'b0;
            r_stg   <= '0;
            r_rdy   <= 1'b0;
            r_tag   <= '0;
            r_infl  <= '0;
            r_tx    <= '0;
        end else begin
            r_state <= w_state;
            r_pos   <= w_pos;
            r_txsh  <= w_txsh;
            r_sl    <= w_sl;
            r_shift <= w_shift;
            r_dslot <= w_dslot;
            r_stg_v <= w_stg_v;
            r_stg   <= w_stg;
            r_rdy   <= w_rdy;
            r_tag   <= w_tag;
            r_infl  <= w_infl;
            r_tx    <= w_tx;
        end
    end

    hamming_deser #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_deser (
        .clk         (clk),
        .RST         (RST),
        .i_shift     (r_shift),
        .i_start     (r_tag[LAT-1]),
        .i_bit       (bus.sl_out),
        .i_ready     (bus.out_ready),
        .o_data      (bus.out_data),
        .o_valid     (bus.out_valid),
        .o_active    (w_cap),
        .stall_req   (w_stall),
        .o_rx_frames (rx_frames)
    );

    assign bus.in_ready = r_rdy;
    assign bus.sl_inn   = r_sl;
    assign bus.shift    = r_shift;
    assign tx_frames    = r_tx;
    assign busy = (r_state != ST_IDLE) || r_stg_v || (r_infl != '0) || w_cap;
endmodule

// File: doc/hamming_link_ctrl.md
# hamming_link_ctrl

Sequencing controller for the serial (15,11) Hamming encoder→decoder chain. It accepts 11-bit words over a valid/ready handshake, serializes them into the chain's serial input in fixed frame slots, and owns the chain's `shift` enable. It tracks frames in flight, deserializes the decoded serial output back into 11-bit words, and stalls the whole chain when the output side back-pressures. It sits between the system's parallel word interface and the serial encoder/decoder pair, which shares `clk` and `RST` with it.

## Interface
- `DATA_W`, 11: payload bits per frame.
- `FRAME_LEN`, 15: shift cycles per frame slot; must be ≥ `DATA_W`.
- `LAT`, 30: shift cycles from payload bit 0 on `sl_inn` to decoded bit 0 on `sl_out`.
- `CNT_W`, 16: width of the frame counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `RST` input 1: synchronous, active-high reset; the same net also resets the datapath.
- `in_data` input `DATA_W`: word to transmit.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: controller accepts `in_data` this cycle.
- `out_data` output `DATA_W`: decoded word.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer takes `out_data`.
- `sl_inn` output 1: serial bit to the encoder (registered).
- `shift` output 1: datapath advance enable (registered).
- `sl_out` input 1: decoded serial bit from the decoder.
- `busy` output 1: a word or frame is in flight.
- `tx_frames` output `CNT_W`: accepted words, wraps.
- `rx_frames` output `CNT_W`: delivered words, wraps.

## Operation
- **Datapath contract.** The datapath advances only in cycles where `shift`=1. The controller never depends on datapath state while `shift`=0.
- **Frame slots.** The `shift` stream is divided into slots of `FRAME_LEN` cycles by a slot counter `0..FRAME_LEN-1`. The counter advances only on `shift` cycles.
  - Data slot: positions `0..DATA_W-1` carry `in_data[k]` in LSB-first order; the remaining positions drive 0.
  - Filler slot: all positions drive 0.
- **TX state machine.**
  - States: IDLE, RUN, DRAIN.
  - IDLE→RUN: on acceptance of a word.
  - RUN: starts a data slot if a word is staged at slot position 0, otherwise a filler slot.
  - RUN→DRAIN: at a slot boundary with no staged word.
  - DRAIN→IDLE: at a slot boundary when the in-flight count is 0 and no word is staged.
  - DRAIN→RUN: on acceptance of a new word.
- **Staging.** One-word staging register. `in_ready` = staging register empty.
  - A staged word is loaded into the TX shifter at the next slot position 0.
  - Acceptance and load in the same cycle are allowed, giving full throughput of one word per `FRAME_LEN` shift cycles.
- **In-flight tracking.** A `LAT`-bit tag shift register, advanced on `shift`, with 1 inserted at position 0 of each data slot.
  - An in-flight counter increments on tag insertion and decrements on RX capture start.
  - The counter has width ⌈log2(LAT/FRAME_LEN+2)⌉.
- **RX capture.** When the tag exits while `shift`=1, capture starts.
  - `sl_out` is sampled on the next `DATA_W` shift cycles, LSB first.
  - On the last bit the word is written to `out_data`, `out_valid` is set, and `rx_frames` is incremented.
- **Back-pressure stall.** `shift` is forced to 0 while `out_valid`=1, `out_ready`=0, and the RX capture is at bit `DATA_W-1`. It resumes the cycle after the handshake.
- **Counters.** `tx_frames` increments on each acceptance; `rx_frames` increments on each delivered word. Both wrap modulo 2^`CNT_W`.
- **`busy`.** `busy` = state≠IDLE or staging register full or in-flight count≠0 or capture active.

## Timing
- **Reset values.** All outputs reset to 0 (`in_ready` reads 1 once the cycle after reset completes). State→IDLE; tags, counters and staging are cleared.
- **Mid-operation reset.** `RST` discards in-flight words; no partial `out_valid` is produced.
- **Word latency.** Accepted at cycle A with an idle chain and no stalls:
  - `shift`=1 and `sl_inn`=bit 0 from A+1.
  - Bit 0 sampled from `sl_out` at A+1+`LAT`.
  - `out_valid`=1 at A+`LAT`+`DATA_W`+1, i.e. A+42 with default parameters.
- **`out_valid` hold.** `out_valid` stays high until `out_valid`&`out_ready`. A new word can overwrite only in the same cycle as that handshake.
- **Simultaneous events.** Acceptance and slot-0 load in the same cycle is legal. Tag insertion and capture start in the same cycle leave the in-flight count unchanged.
- **Drain.** The DRAIN state shifts filler slots until the last tagged frame has been captured. `shift` then falls at a slot boundary, so the datapath's internal framing stays aligned.

## Structure
- Shared package `hamming_pkg`:
  - Constants `HAM_DATA_W`=11, `HAM_CODE_W`=15.
  - TX state enum.
- Sub-module `hamming_deser`: RX capture shifter, bit counter and output register with valid/ready. It exposes a `stall_req` output to the top-level controller.

## Test plan
- **Single word.** Single word `11'h5A5` into an idle chain with `out_ready`=1 → `out_data`=`11'h5A5` at acceptance+42, `tx_frames`=`rx_frames`=1, `busy` falls at a slot boundary.
- **Back-to-back stream.** Eight back-to-back words `11'h001`,`002`,…,`080` → `in_ready` gives one acceptance per 15 `shift` cycles, and outputs arrive in order, 15 cycles apart.
- **Output stall.** Hold `out_ready`=0 with three words in flight → `shift` falls at the final capture bit, the first word holds on `out_data`, and releasing `out_ready` delivers all three with no loss or duplication.
- **Input gap.** A 40-cycle gap between words `11'h7FF` and `11'h000` → filler slots are inserted and the second word starts exactly at a slot boundary, at a multiple of 15 shift cycles after the first.
- **Mid-frame reset.** Assert `RST` mid-frame at bit 6 → all outputs are 0 the next cycle, no stray `out_valid`, and the next word round-trips correctly.
- **Counter wrap.** Preload via 65 537 words (or force) → `tx_frames` wraps to 1 with `rx_frames` matching after drain.
